// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - tile types, map dimensions and tile colours for the game map
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FRAME   = 2'd1,
    PLAYER1 = 2'd2,
    PLAYER2 = 2'd3
  } tile_t;

  localparam int MAP_WIDTH  = 32;
  localparam int MAP_HEIGHT = 24;

  localparam logic [11:0] COLOR_EMPTY = 12'h111;
  localparam logic [11:0] COLOR_FRAME = 12'hFFF;
  localparam logic [11:0] COLOR_P1    = 12'h0F0;
  localparam logic [11:0] COLOR_P2    = 12'h00F;
  localparam logic [11:0] COLOR_CRASH = 12'hF00;
  localparam logic [11:0] COLOR_GRID  = 12'h333;

endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing field widths shared by the video pipeline stages
package vga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;
  localparam int RGB_W    = 12;

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - async-reset shift register delaying a packed signal bundle
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // shift the bundle one stage per clock, flushing to zero on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_map.sv
// rtl/draw_map.sv - renders the live tile map into the VGA stream, 3-cycle latency; DRAW_MAP_GRID_EN adds grid lines on EMPTY tiles
module draw_map
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int MAP_X0       = 128,
  parameter int MAP_Y0       = 64,
  parameter int TILE_SIZE    = 8,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [RGB_W-1:0]    rgb_in,
  input  tile_t               map [MAP_WIDTH][MAP_HEIGHT],
  input  logic                player1_collision,
  input  logic                player2_collision,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out
);

  localparam int TILE_SHIFT = $clog2(TILE_SIZE);
  localparam int TX_W       = $clog2(MAP_WIDTH);
  localparam int TY_W       = $clog2(MAP_HEIGHT);
  localparam int CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BUNDLE_W   = HCOUNT_W + VCOUNT_W + 4 + RGB_W;

  localparam logic [HCOUNT_W-1:0] AREA_W  = HCOUNT_W'(MAP_WIDTH * TILE_SIZE);
  localparam logic [VCOUNT_W-1:0] AREA_H  = VCOUNT_W'(MAP_HEIGHT * TILE_SIZE);
  localparam logic [CNT_W-1:0]    CNT_TOP = CNT_W'(BLINK_FRAMES - 1);

  // pixel position relative to tile (0,0); left/above the origin wraps to a large value
  logic [HCOUNT_W-1:0] w_hrel;
  logic [VCOUNT_W-1:0] w_vrel;
  logic                w_in_area;

  assign w_hrel    = hcount_in - HCOUNT_W'(MAP_X0);
  assign w_vrel    = vcount_in - VCOUNT_W'(MAP_Y0);
  assign w_in_area = (w_hrel < AREA_W) && (w_vrel < AREA_H);

  // stage 1: tile coordinates
  logic            r_in_area1;
  logic [TX_W-1:0] r_tx;
  logic [TY_W-1:0] r_ty;

  // stage 2: tile type
  tile_t           r_tile2;
  logic            r_in_area2;

`ifdef DRAW_MAP_GRID_EN
  logic [TILE_SHIFT-1:0] r_lx1;
  logic [TILE_SHIFT-1:0] r_ly1;
  logic                  r_edge2;
`endif

  // stage 1: area test and tile index from the incoming pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_area1 <= 1'b0;
      r_tx       <= '0;
      r_ty       <= '0;
`ifdef DRAW_MAP_GRID_EN
      r_lx1      <= '0;
      r_ly1      <= '0;
`endif
    end else begin
      r_in_area1 <= w_in_area;
      r_tx       <= w_hrel[TILE_SHIFT +: TX_W];
      r_ty       <= w_vrel[TILE_SHIFT +: TY_W];
`ifdef DRAW_MAP_GRID_EN
      r_lx1      <= w_hrel[TILE_SHIFT-1:0];
      r_ly1      <= w_vrel[TILE_SHIFT-1:0];
`endif
    end
  end

  // stage 2: live map lookup, outside the play area reads as EMPTY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tile2    <= EMPTY;
      r_in_area2 <= 1'b0;
`ifdef DRAW_MAP_GRID_EN
      r_edge2    <= 1'b0;
`endif
    end else begin
      r_tile2    <= r_in_area1 ? map[r_tx][r_ty] : EMPTY;
      r_in_area2 <= r_in_area1;
`ifdef DRAW_MAP_GRID_EN
      r_edge2    <= (r_lx1 == '0) || (r_ly1 == '0);
`endif
    end
  end

  // timing signals ride two stages here; the output register adds the third
  logic [BUNDLE_W-1:0] w_bundle_in;
  logic [BUNDLE_W-1:0] w_bundle2;
  logic [HCOUNT_W-1:0] w_hcount2;
  logic [VCOUNT_W-1:0] w_vcount2;
  logic                w_hsync2;
  logic                w_vsync2;
  logic                w_hblnk2;
  logic                w_vblnk2;
  logic [RGB_W-1:0]    w_rgb2;

  assign w_bundle_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
  assign {w_hcount2, w_vcount2, w_hsync2, w_vsync2, w_hblnk2, w_vblnk2, w_rgb2} = w_bundle2;

  sync_delay #(
    .WIDTH (BUNDLE_W),
    .DEPTH (2)
  ) u_sync_delay (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_bundle_in),
    .o_data (w_bundle2)
  );

  // blink state: frame counter advanced by vsync rising edges
  logic             r_vsync_prev;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_phase1;
  logic             r_phase2;
  logic             w_vs_rise;
  logic             w_wrap;
  logic             w_blink1;
  logic             w_blink2;

  assign w_vs_rise = vsync_in & ~r_vsync_prev;
  assign w_wrap    = w_vs_rise && (r_frame_cnt == CNT_TOP);
  // a dropped collision hides the crash colour on the very next pixel
  assign w_blink1  = r_phase1 & player1_collision;
  assign w_blink2  = r_phase2 & player2_collision;

  // count frames and toggle each crashed player's phase at every wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_prev <= 1'b0;
      r_frame_cnt  <= '0;
      r_phase1     <= 1'b0;
      r_phase2     <= 1'b0;
    end else begin
      r_vsync_prev <= vsync_in;
      if (w_vs_rise) begin
        r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + CNT_W'(1);
      end
      if (!player1_collision) begin
        r_phase1 <= 1'b0;
      end else if (w_wrap) begin
        r_phase1 <= ~r_phase1;
      end
      if (!player2_collision) begin
        r_phase2 <= 1'b0;
      end else if (w_wrap) begin
        r_phase2 <= ~r_phase2;
      end
    end
  end

  // stage 3 colour select: blanking, then background, then tile colour
  logic [RGB_W-1:0] w_color;

  always_comb begin
    w_color = COLOR_EMPTY;
    if (w_hblnk2 || w_vblnk2) begin
      w_color = '0;
    end else if (!r_in_area2) begin
      w_color = w_rgb2;
    end else begin
      case (r_tile2)
        FRAME:   w_color = COLOR_FRAME;
        PLAYER1: w_color = w_blink1 ? COLOR_CRASH : COLOR_P1;
        PLAYER2: w_color = w_blink2 ? COLOR_CRASH : COLOR_P2;
`ifdef DRAW_MAP_GRID_EN
        default: w_color = r_edge2 ? COLOR_GRID : COLOR_EMPTY;
`else
        default: w_color = COLOR_EMPTY;
`endif
      endcase
    end
  end

  // output register: third pipeline stage for colour and timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= w_hcount2;
      vcount_out <= w_vcount2;
      hsync_out  <= w_hsync2;
      vsync_out  <= w_vsync2;
      hblnk_out  <= w_hblnk2;
      vblnk_out  <= w_vblnk2;
      rgb_out    <= w_color;
    end
  end

endmodule

// File: tb/tb_draw_map.sv
// tb/tb_draw_map.sv - table-driven and sequence checks for draw_map
module tb_draw_map;
  import game_pkg::*;

`ifdef DRAW_MAP_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif
  localparam logic [11:0] EXP_GRID = GRID ? COLOR_GRID : COLOR_EMPTY;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  tile_t       tmap [MAP_WIDTH][MAP_HEIGHT];
  logic        p1_col, p2_col;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;

  draw_map dut (
    .clk               (clk),
    .rst               (rst),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .hsync_in          (hsync_in),
    .vsync_in          (vsync_in),
    .hblnk_in          (hblnk_in),
    .vblnk_in          (vblnk_in),
    .rgb_in            (rgb_in),
    .map               (tmap),
    .player1_collision (p1_col),
    .player2_collision (p2_col),
    .hcount_out        (hcount_out),
    .vcount_out        (vcount_out),
    .hsync_out         (hsync_out),
    .vsync_out         (vsync_out),
    .hblnk_out         (hblnk_out),
    .vblnk_out         (vblnk_out),
    .rgb_out           (rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic show(input logic [10:0] h, input logic [10:0] v);
    hcount_in = h;
    vcount_in = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic vs_pulse(input int n);
    for (int k = 0; k < n; k++) begin
      vsync_in = 1'b1;
      @(negedge clk);
      vsync_in = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{11'd128, 11'd64,  1'b0, 1'b0, 12'h000, COLOR_FRAME};
    vecs[1]  = '{11'd168, 11'd120, 1'b0, 1'b0, 12'h000, COLOR_P1};
    vecs[2]  = '{11'd176, 11'd120, 1'b0, 1'b0, 12'h000, EXP_GRID};
    vecs[3]  = '{11'd177, 11'd121, 1'b0, 1'b0, 12'h000, COLOR_EMPTY};
    vecs[4]  = '{11'd168, 11'd120, 1'b1, 1'b0, 12'h777, 12'h000};
    vecs[5]  = '{11'd168, 11'd120, 1'b0, 1'b1, 12'h777, 12'h000};
    vecs[6]  = '{11'd127, 11'd64,  1'b0, 1'b0, 12'hABC, 12'hABC};
    vecs[7]  = '{11'd384, 11'd64,  1'b0, 1'b0, 12'hABC, 12'hABC};
    vecs[8]  = '{11'd128, 11'd63,  1'b0, 1'b0, 12'h5A5, 12'h5A5};
    vecs[9]  = '{11'd128, 11'd256, 1'b0, 1'b0, 12'h5A5, 12'h5A5};
    vecs[10] = '{11'd383, 11'd255, 1'b0, 1'b0, 12'h123, COLOR_P2};
    vecs[11] = '{11'd200, 11'd90,  1'b0, 1'b0, 12'h000, COLOR_FRAME};
    vecs[12] = '{11'd0,   11'd0,   1'b0, 1'b0, 12'h123, 12'h123};
    vecs[13] = '{11'd10,  11'd0,   1'b1, 1'b0, 12'h5A5, 12'h000};

    for (int x = 0; x < MAP_WIDTH; x++)
      for (int y = 0; y < MAP_HEIGHT; y++)
        tmap[x][y] = EMPTY;
    tmap[0][0]   = FRAME;
    tmap[5][7]   = PLAYER1;
    tmap[9][3]   = FRAME;
    tmap[31][23] = PLAYER2;

    rst = 1'b1;
    hcount_in = 11'd100; vcount_in = 11'd50;
    hsync_in = 1'b1; vsync_in = 1'b0; hblnk_in = 1'b1; vblnk_in = 1'b1;
    rgb_in = 12'hABC; p1_col = 1'b0; p2_col = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rgb",    rgb_out,    0);
    chk("reset_hcount", hcount_out, 0);
    chk("reset_hsync",  hsync_out,  0);
    chk("reset_hblnk",  hblnk_out,  0);
    hsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rst = 1'b0;

    // table: hold each pixel for the full pipeline depth, then compare
    for (int i = 0; i < NV; i++) begin
      hcount_in = vecs[i].h;
      vcount_in = vecs[i].v;
      hblnk_in  = vecs[i].hb;
      vblnk_in  = vecs[i].vb;
      rgb_in    = vecs[i].rgb;
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_rgb", i),    rgb_out,    vecs[i].exp);
      chk($sformatf("vec%0d_hcount", i), hcount_out, vecs[i].h);
      chk($sformatf("vec%0d_vcount", i), vcount_out, vecs[i].v);
      chk($sformatf("vec%0d_hblnk", i),  hblnk_out,  vecs[i].hb);
    end
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'h000;

    // mid-frame reset clears outputs at once, valid output 3 cycles after release
    show(11'd168, 11'd120);
    chk("pre_reset_rgb", rgb_out, COLOR_P1);
    rst = 1'b1;
    #1;
    chk("async_reset_rgb",    rgb_out,    0);
    chk("async_reset_hcount", hcount_out, 0);
    @(negedge clk);
    hcount_in = 11'd128; vcount_in = 11'd64;
    rst = 1'b0;
    @(negedge clk);
    chk("release_c1_rgb", rgb_out, 0);
    @(negedge clk);
    chk("release_c2_rgb", rgb_out, 0);
    @(negedge clk);
    chk("release_c3_rgb",    rgb_out,    COLOR_FRAME);
    chk("release_c3_hcount", hcount_out, 128);

    // single-cycle hsync pulse re-emerges exactly 3 cycles later
    hsync_in = 1'b1;
    @(negedge clk);
    hsync_in = 1'b0;
    @(negedge clk);
    chk("hsync_d2", hsync_out, 0);
    @(negedge clk);
    chk("hsync_d3", hsync_out, 1);
    @(negedge clk);
    chk("hsync_d4", hsync_out, 0);

    // blink: restart frame counter, collision raised mid-count
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    show(11'd168, 11'd120);
    chk("blink_idle", rgb_out, COLOR_P1);
    vs_pulse(5);
    chk("vsync_out_low", vsync_out, 0);
    p1_col = 1'b1;
    @(negedge clk);
    chk("blink_no_instant", rgb_out, COLOR_P1);
    vs_pulse(10);
    chk("blink_cnt15", rgb_out, COLOR_P1);
    vs_pulse(1);
    chk("blink_wrap1_p1", rgb_out, COLOR_CRASH);
    show(11'd383, 11'd255);
    chk("blink_wrap1_p2", rgb_out, COLOR_P2);
    show(11'd168, 11'd120);
    vs_pulse(8);
    chk("blink_mid_half", rgb_out, COLOR_CRASH);
    vs_pulse(8);
    chk("blink_wrap2_p1", rgb_out, COLOR_P1);
    vs_pulse(16);
    chk("blink_wrap3_p1", rgb_out, COLOR_CRASH);
    show(11'd383, 11'd255);
    chk("blink_wrap3_p2", rgb_out, COLOR_P2);
    show(11'd168, 11'd120);
    p1_col = 1'b0;
    @(negedge clk);
    chk("blink_drop", rgb_out, COLOR_P1);

    // grid boundary: FRAME keeps its colour at lx=0
    show(11'd200, 11'd88);
    chk("frame_lx0", rgb_out, COLOR_FRAME);
    show(11'd184, 11'd124);
    chk("empty_lx0", rgb_out, EXP_GRID);
    show(11'd185, 11'd124);
    chk("empty_lx1", rgb_out, COLOR_EMPTY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
